// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 asynchronous serial receiver with mid-bit sampling, valid strobe
//            and framing status. Define UART_RX_PARITY_EN for 8E1 with parity_err.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int c_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CW-1:0] c_HALF_M1 = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CW-1:0] c_FULL_M1 = c_CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_START     = 3'd1;
  localparam logic [2:0] c_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_PARITY    = 3'd3;
`endif
  localparam logic [2:0] c_STOP      = 3'd4;
  localparam logic [2:0] c_WAIT_HIGH = 3'd5;

  logic            r_sync1;
  logic            r_rxd_s;
  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [c_CW-1:0] r_baud;
  logic [3:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            w_tick_half;
  logic            w_tick_full;
  logic            w_sample;
  logic            w_stop_sample;
  logic            w_par_bad;
  logic            w_good;

  assign w_tick_half = (r_baud == c_HALF_M1);
  assign w_tick_full = (r_baud == c_FULL_M1);

  // Synchroniser idles high so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_sync1 <= RxD;
      r_rxd_s <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:      if (!r_rxd_s) w_state_nxt = c_START;
      c_START:     if (w_tick_half) w_state_nxt = r_rxd_s ? c_IDLE : c_DATA;
      c_DATA: begin
        if (w_tick_full && (r_bitcnt == 4'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = c_PARITY;
`else
          w_state_nxt = c_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      c_PARITY:    if (w_tick_full) w_state_nxt = c_STOP;
`endif
      // A low stop bit may be a break; hold off until the line returns high.
      c_STOP:      if (w_tick_full) w_state_nxt = r_rxd_s ? c_IDLE : c_WAIT_HIGH;
      c_WAIT_HIGH: if (r_rxd_s) w_state_nxt = c_IDLE;
      default:     w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    busy          = (r_state != c_IDLE);
    w_sample      = 1'b0;
    w_stop_sample = 1'b0;
    case (r_state)
      c_START: w_sample = w_tick_half;
      c_DATA:  w_sample = w_tick_full;
`ifdef UART_RX_PARITY_EN
      c_PARITY: w_sample = w_tick_full;
`endif
      c_STOP: begin
        w_sample      = w_tick_full;
        w_stop_sample = w_tick_full;
      end
      default: w_sample = 1'b0;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;

  always_ff @(posedge clk) begin
    if (reset)                                  r_par_bit <= 1'b0;
    else if ((r_state == c_PARITY) && w_tick_full) r_par_bit <= r_rxd_s;
  end

  assign w_par_bad = (^r_shift) ^ r_par_bit;

  always_ff @(posedge clk) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= w_stop_sample && w_par_bad;
  end
`else
  assign w_par_bad = 1'b0;
`endif

  assign w_good = w_stop_sample && r_rxd_s && !w_par_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_baud    <= '0;
      r_bitcnt  <= 4'd0;
      r_shift   <= 8'h00;
      data      <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if ((r_state == c_IDLE) || (r_state == c_WAIT_HIGH) || w_sample) r_baud <= '0;
      else                                                           r_baud <= r_baud + c_CW'(1);

      if (r_state == c_START)                 r_bitcnt <= 4'd0;
      else if ((r_state == c_DATA) && w_tick_full) r_bitcnt <= r_bitcnt + 4'd1;

      // LSB arrives first, so each bit enters at the top and shifts down.
      if ((r_state == c_DATA) && w_tick_full) r_shift <= {r_rxd_s, r_shift[7:1]};

      rx_valid  <= w_good;
      frame_err <= w_stop_sample && !r_rxd_s;
      if (w_good) data <= r_shift;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// tb_uart_rx: randomized and directed frames against a frame-level model;
// a monitor scoreboards every strobe (flags, data, arrival cycle).
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] data;
  logic       rx_valid, frame_err, busy, parity_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .RxD(RxD), .data(data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    bit         v;
    bit         fe;
    bit         pe;
    int         at;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         total = 0;
  int         bad = 0;
  int         busy_cnt = 0;
  logic [7:0] model_data = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic bitwait();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Frame-level model: outcome decided by stop bit and even parity alone.
  task automatic send_frame(input logic [7:0] b, input bit stopb, input bit flip_par);
    exp_t e;
    bit   p;
    p    = (^b) ^ flip_par;
    e.at = cyc + 2 + HALF + CPB * (NB - 1) + 1;
    e.fe = !stopb;
    e.pe = (NB == 11) && flip_par;
    e.v  = stopb && !e.pe;
    e.d  = e.v ? b : model_data;
    if (e.v) model_data = b;
    q.push_back(e);
    RxD = 1'b0;
    bitwait();
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      bitwait();
    end
    if (NB == 11) begin
      RxD = p;
      bitwait();
    end
    RxD = stopb;
    bitwait();
  endtask

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (rx_valid || frame_err || parity_err) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got v=%0b fe=%0b pe=%0b expected none", rx_valid, frame_err, parity_err);
      end else begin
        mon_e = q.pop_front();
        chk("rx_valid", rx_valid, mon_e.v);
        chk("frame_err", frame_err, mon_e.fe);
        chk("parity_err", parity_err, mon_e.pe);
        chk("data", data, mon_e.d);
        chk("strobe_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_data"}, data, 8'h00);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_parity_err"}, parity_err, 0);
    chk({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] aborted;
    bit         stopb, flip;
    reset = 1'b1;
    RxD   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_vals("reset");
    bitwait();

    send_frame(8'hA5, 1'b1, 1'b0);
    bitwait();
    bitwait();

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    bitwait();

    busy_cnt = 0;
    RxD = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    RxD = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    chk("glitch_busy_cycles", busy_cnt, HALF);

    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) bitwait();
    chk("break_busy", busy, 1);
    chk("break_data", data, model_data);
    RxD = 1'b1;
    bitwait();
    chk("after_break_busy", busy, 0);
    send_frame(8'h66, 1'b1, 1'b0);
    bitwait();

    aborted = 8'h5A;
    RxD = 1'b0;
    bitwait();
    for (int i = 0; i < 5; i++) begin
      RxD = aborted[i];
      if (i < 4) bitwait();
    end
    repeat (HALF) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_data = 8'h00;
    check_reset_vals("midframe_reset");
    RxD = 1'b1;
    bitwait();
    bitwait();
    send_frame(8'hC3, 1'b1, 1'b0);
    bitwait();

    if (NB == 11) begin
      send_frame(8'h07, 1'b1, 1'b0);
      send_frame(8'h07, 1'b1, 1'b1);
      bitwait();
    end

    repeat (24) begin
      b     = 8'($urandom);
      stopb = ($urandom_range(0, 5) != 0);
      flip  = ($urandom_range(0, 3) == 0);
      send_frame(b, stopb, flip);
      if (!stopb) begin
        RxD = 1'b1;
        bitwait();
      end else if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;
      end
    end

    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    chk("final_data", data, model_data);
    chk("final_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for 8N1 frames, the receive-side counterpart of the team's UART transmitter. It sits between the external RxD pin and the byte-consuming logic. It synchronises the line, detects a start bit, samples each bit at its centre using a baud divider, and presents each received byte with a one-cycle valid strobe and framing status.

## Interface
- `CLKS_PER_BIT`, 10416 — clock cycles per bit period; legal range 4..65535.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `RxD`  input  1  serial line, idle high, asynchronous to `clk`.
- `data`  output  8  last received byte, LSB received first; held until the next good frame.
- `rx_valid`  output  1  one-cycle pulse when `data` is updated with a good frame.
- `frame_err`  output  1  one-cycle pulse when the stop bit samples low.
- `busy`  output  1  high while state is not IDLE.
- `parity_err`  output  1  one-cycle pulse on parity mismatch; present only with `UART_RX_PARITY_EN`.

## Operation
- `RxD` passes through a 2-flop synchroniser (`rxd_s`). All decisions use `rxd_s`.
- Baud counter width is $clog2(CLKS_PER_BIT). `HALF` = CLKS_PER_BIT/2, using integer truncation.
- The 4-bit bit counter indexes the data bits 0..7.
- States:
  - IDLE: if `rxd_s`==0, go to START and clear the baud counter.
  - START: count to HALF-1, then sample `rxd_s`.
    - If 1 (false start / glitch): return to IDLE with no strobe.
    - If 0: clear the counter and the bit counter, then go to DATA.
  - DATA: count to CLKS_PER_BIT-1, then sample `rxd_s` into the shift register MSB and shift right.
    - After the 8th sample, go to STOP (or PARITY when the macro is defined).
  - PARITY (macro only): count to CLKS_PER_BIT-1, then sample the parity bit and go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample the stop bit.
    - If 1: load `data` from the shift register, pulse `rx_valid`, and go to IDLE.
    - If 0: pulse `frame_err`, leave `data` unchanged, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxd_s`==1, then go to IDLE. This prevents a break condition (line held low) from re-triggering as a start bit.
- The receiver returns to IDLE at the mid-stop sample and does not wait for the end of the stop bit. Back-to-back frames with a single stop bit are therefore received.
- There is no consumer backpressure. A new frame overwrites `data`; the consumer must capture it on `rx_valid`.
- Parity error and framing error on the same frame: both pulses are asserted in the same cycle, and `rx_valid` stays 0.

## Timing
- Reset values: `data`=8'h00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0. The state, both counters, the shift register and the synchroniser (forced to 1) are all reset.
- Reset asserted mid-frame aborts the frame with no strobe. Reception resumes at the next falling edge seen after reset deasserts.
- The synchroniser adds 2 cycles: the `RxD` falling edge reaches IDLE detection 2 cycles later.
- Start sample: HALF cycles after entering START. Each later sample is CLKS_PER_BIT cycles after the previous one.
- `rx_valid`, `frame_err` and `parity_err` are registered. They assert the cycle after the stop sample, are high for exactly 1 cycle, and `data` is valid in that same cycle.
- `busy` rises the cycle after start detection and falls the cycle `rx_valid`/`frame_err` asserts. In WAIT_HIGH, `busy` stays high until the return to IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame is start + 8 data + even parity + stop (11 bits) and the PARITY state exists.
  - `parity_err` pulses if the XOR of the data bits and the parity bit is 1. `data` is not updated and `rx_valid` is not asserted on a parity error.
- Not defined:
  - The frame is 8N1 (10 bits), the PARITY state is absent, and the `parity_err` port does not exist.

## Test plan
- CLKS_PER_BIT=16, send 8'hA5 as 8N1 at exact baud -> one `rx_valid` pulse with `data`=8'hA5, 2+8+16*9+1 cycles after the start edge; `frame_err` stays 0.
- Send 8'h00 then 8'hFF back-to-back with one stop bit -> two `rx_valid` pulses, `data` 8'h00 then 8'hFF, with no missed frame.
- 4-cycle low glitch on an idle line -> returns to IDLE at the START sample with no strobes; `busy` is high for HALF cycles only.
- Frame 8'h3C with stop bit forced 0, then line held low for 40 bit times -> one `frame_err` pulse, `data` keeps its previous value, and no further strobes until the line goes high and a new start arrives.
- Assert `reset` for 1 cycle at bit 4 of 8'h5A, then send 8'hC3 -> no strobe for the aborted frame, then `rx_valid` with 8'hC3; outputs read reset values in the cycle after reset.
- `UART_RX_PARITY_EN`: send 8'h07 with parity 1 -> `rx_valid`, `data`=8'h07. Send 8'h07 with parity 0 -> `parity_err` pulse, no `rx_valid`.
